// File: rtl/aes_dec_ctrl.sv
// AES-128 inverse-cipher round sequencer for an external round datapath.
// Define AES_DEC_CTRL_ABORT_EN to add the abort input.
module aes_dec_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic [3:0]   rk_addr,
  input  logic [127:0] rk_data,
  output logic [127:0] dp_block,
  output logic [127:0] dp_round_key,
  output logic         dp_last,
  input  logic [127:0] dp_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
`ifdef AES_DEC_CTRL_ABORT_EN
  input  logic         abort,
`endif
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } state_e;

  state_e       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [3:0]   rc_q, rc_d;
  logic [3:0]   rk_addr_q, rk_addr_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         busy_q, busy_d;
  logic         dp_last_q, dp_last_d;
  logic         abort_act;

`ifdef AES_DEC_CTRL_ABORT_EN
  assign abort_act = abort && (state_q != IDLE);
`else
  assign abort_act = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rc_d    = rc_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d    = in_block ^ rk_data;
          rc_d    = 4'd9;
          state_d = ROUND;
        end
      end
      ROUND: begin
        st_d = dp_result;
        rc_d = rc_q - 4'd1;
        if (rc_q == 4'd1) state_d = FINAL;
      end
      FINAL: begin
        st_d    = dp_result;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // abort wins over the output handshake
    if (abort_act) begin
      state_d = IDLE;
      st_d    = '0;
      rc_d    = 4'd0;
    end
  end

  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    dp_last_d   = 1'b0;
    rk_addr_d   = 4'd0;
    unique case (state_d)
      IDLE: begin
        in_ready_d = 1'b1;
        rk_addr_d  = 4'd10;
      end
      ROUND: begin
        busy_d    = 1'b1;
        rk_addr_d = rc_d;
      end
      FINAL: begin
        busy_d    = 1'b1;
        dp_last_d = 1'b1;
      end
      DONE: out_valid_d = 1'b1;
      default: in_ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      st_q        <= '0;
      rc_q        <= 4'd0;
      rk_addr_q   <= 4'd10;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      dp_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      rc_q        <= rc_d;
      rk_addr_q   <= rk_addr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      dp_last_q   <= dp_last_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign busy         = busy_q;
  assign dp_last      = dp_last_q;
  assign rk_addr      = rk_addr_q;
  assign dp_block     = st_q;
  assign out_block    = st_q;
  assign dp_round_key = rk_data;

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Directed bench for aes_dec_ctrl with a behavioural AES
// inverse-round datapath and expanded key store.
module tb_aes_dec_ctrl;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_block = '0;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic [127:0] dp_block;
  logic [127:0] dp_round_key;
  logic         dp_last;
  logic [127:0] dp_result;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_block;
  logic         busy;
`ifdef AES_DEC_CTRL_ABORT_EN
  logic         abort = 1'b0;
`endif

  logic [7:0]   sbox [256];
  logic [7:0]   isbox[256];
  logic [127:0] rks  [11];

  int errors = 0;
  int checks = 0;

  aes_dec_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_block(in_block),
    .rk_addr(rk_addr),
    .rk_data(rk_data),
    .dp_block(dp_block),
    .dp_round_key(dp_round_key),
    .dp_last(dp_last),
    .dp_result(dp_result),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_block(out_block),
`ifdef AES_DEC_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] b, int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic build_tables();
    logic [7:0]  inv;
    logic [7:0]  s;
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rcon;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
        ^ rotl(inv, 4) ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]],
             sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last
  function automatic logic [127:0] inv_round(logic [127:0] s,
                                             logic [127:0] k,
                                             logic last);
    logic [7:0]   a[16];
    logic [7:0]   b[16];
    logic [7:0]   m[4];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        b[w+4*c] = isbox[a[w+4*((c-w+4)%4)]]
                 ^ k[127-8*(w+4*c) -: 8];
    if (!last)
      for (int c = 0; c < 4; c++) begin
        for (int w = 0; w < 4; w++) m[w] = b[w+4*c];
        b[4*c]   = gmul(8'h0e, m[0]) ^ gmul(8'h0b, m[1])
                 ^ gmul(8'h0d, m[2]) ^ gmul(8'h09, m[3]);
        b[4*c+1] = gmul(8'h09, m[0]) ^ gmul(8'h0e, m[1])
                 ^ gmul(8'h0b, m[2]) ^ gmul(8'h0d, m[3]);
        b[4*c+2] = gmul(8'h0d, m[0]) ^ gmul(8'h09, m[1])
                 ^ gmul(8'h0e, m[2]) ^ gmul(8'h0b, m[3]);
        b[4*c+3] = gmul(8'h0b, m[0]) ^ gmul(8'h0d, m[1])
                 ^ gmul(8'h09, m[2]) ^ gmul(8'h0e, m[3]);
      end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    return r;
  endfunction

  always_comb begin
    rk_data = '0;
    if (rk_addr <= 4'd10) rk_data = rks[rk_addr];
  end

  always_comb dp_result = inv_round(dp_block, dp_round_key, dp_last);

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_dp_last"}, 128'(dp_last), 128'(0));
    chk({tag, "_rk_addr"}, 128'(rk_addr), 128'(10));
    chk({tag, "_dp_block"}, dp_block, 128'(0));
  endtask

  task automatic run_block(input string tag);
    int n;
    in_block = CT;
    in_valid = 1'b1;
    chk({tag, "_accept_rdy"}, 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 128'(n), 128'(10));
    chk({tag, "_pt"}, out_block, PT);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_back_idle"}, 128'(in_ready), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int busy_n;
    int nout;
    int n;
    int acc[$];
    build_tables();
    #2 rst_n = 1'b0;
    repeat (2) tick();
    chk_reset("reset");
    chk("reset_key", dp_round_key, rks[10]);
    rst_n = 1'b1;
    tick();

    // C.1 vector with key-fetch order, then back-pressure
    in_block = CT;
    in_valid = 1'b1;
    chk("idle_rk", 128'(rk_addr), 128'(10));
    tick();
    in_valid = 1'b0;
    chk("ark0", dp_block, CT ^ rks[10]);
    busy_n = 0;
    for (int j = 1; j <= 10; j++) begin
      chk("rk_seq", 128'(rk_addr), 128'(10 - j));
      chk("dp_last", 128'(dp_last), 128'(j == 10));
      chk("busy_rdy", 128'(in_ready), 128'(0));
      chk("early_ov", 128'(out_valid), 128'(0));
      if (busy) busy_n++;
      tick();
    end
    chk("c1_ov", 128'(out_valid), 128'(1));
    chk("c1_pt", out_block, PT);
    chk("busy_cycles", 128'(busy_n), 128'(10));
    chk("done_rk", 128'(rk_addr), 128'(0));
    for (int j = 0; j < 20; j++) begin
      chk("bp_ov", 128'(out_valid), 128'(1));
      chk("bp_blk", out_block, PT);
      chk("bp_rdy", 128'(in_ready), 128'(0));
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_rel_ov", 128'(out_valid), 128'(0));
    chk("bp_rel_rdy", 128'(in_ready), 128'(1));

    // back-to-back blocks
    in_block = CT;
    in_valid = 1'b1;
    out_ready = 1'b1;
    nout = 0;
    for (int cyc = 0; cyc < 40 && nout < 2; cyc++) begin
      if (in_ready && in_valid) acc.push_back(cyc);
      if (busy) chk("b2b_rdy", 128'(in_ready), 128'(0));
      if (out_valid) begin
        chk("b2b_pt", out_block, PT);
        nout++;
      end
      tick();
      if (acc.size() == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_nout", 128'(nout), 128'(2));
    chk("b2b_nacc", 128'(acc.size()), 128'(2));
    if (acc.size() == 2)
      chk("b2b_gap", 128'(acc[1] - acc[0]), 128'(12));

    // reset in the middle of a block
    in_block = CT;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (rk_addr != 4'd5 && n < 20) begin
      tick();
      n++;
    end
    chk("rst_wait", 128'(rk_addr), 128'(5));
    #2 rst_n = 1'b0;
    #1 chk_reset("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    run_block("after_rst");

`ifdef AES_DEC_CTRL_ABORT_EN
    in_block = CT;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (rk_addr != 4'd4 && n < 20) begin
      tick();
      n++;
    end
    chk("abort_wait", 128'(rk_addr), 128'(4));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_reset("abort");
    n = 0;
    for (int j = 0; j < 12; j++) begin
      if (out_valid) n++;
      tick();
    end
    chk("abort_no_ov", 128'(n), 128'(0));
    run_block("after_abort");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_dec_ctrl.md
# aes_dec_ctrl

Sequencer for the AES-128 inverse-cipher round datapath (the `inv_mixColumn`-based `AES_core` round logic). It accepts a ciphertext block over a valid/ready handshake and fetches round keys 10 down to 0 from the external key store. It steps the shared round datapath through the initial AddRoundKey, nine full inverse rounds and the final inverse round, then returns the plaintext over a second valid/ready handshake. One block is in flight at a time; the datapath itself is combinational and external.

## Interface
- No parameters; AES-128 only, 10 rounds fixed.
- Clock `clk` and active-low reset `rst_n` are decided: one clock, reset asynchronous and active-low.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  ciphertext offered
- `in_ready`  out  1  controller can accept a block
- `in_block`  in  128  ciphertext, byte 0 in [127:120]
- `rk_addr`  out  4  round-key index requested (0..10)
- `rk_data`  in  128  round key for `rk_addr`, valid in the same cycle (combinational read)
- `dp_block`  out  128  state register driven to the round datapath
- `dp_round_key`  out  128  equals `rk_data`, passed through
- `dp_last`  out  1  1 = final round (skip InvMixColumns), 0 = full round
- `dp_result`  in  128  combinational datapath output
- `out_valid`  out  1  plaintext available
- `out_ready`  in  1  consumer accepts plaintext
- `out_block`  out  128  plaintext, equals the state register
- `busy`  out  1  high in the ROUND and FINAL states
- `abort`  in  1  present only with `AES_DEC_CTRL_ABORT_EN` defined

## Operation
- States: IDLE, ROUND, FINAL, DONE. 128-bit state register `st` and 4-bit round counter `rc`.
- IDLE: `in_ready`=1 and `rk_addr`=10. On `in_valid & in_ready`: `st` <= `in_block ^ rk_data`, `rc` <= 9, go to ROUND.
- ROUND: `rk_addr`=`rc`, `dp_last`=0. Each cycle `st` <= `dp_result` and `rc` decrements. When `rc`==1 at the edge, go to FINAL with `rc` <= 0.
- FINAL: `rk_addr`=0, `dp_last`=1, `st` <= `dp_result`, go to DONE.
- DONE: `out_valid`=1. `out_block`=`st` is held stable until `out_valid & out_ready`, then go to IDLE.
- `in_ready` is 0 in every state except IDLE. There is no same-cycle bypass from DONE to a new accept.
- `dp_block`=`st` at all times. `dp_last`=0 outside FINAL. `rk_addr` is 0 in DONE.
- `in_block` and `in_valid` are ignored outside IDLE. `out_ready` is ignored outside DONE.

## Timing
- Reset values: state IDLE, `st`=0, `rc`=0, `in_ready`=1, `out_valid`=0, `busy`=0, `dp_last`=0, `rk_addr`=10.
- The accept edge is E0. Rounds 9..1 update at edges E1..E9, the final round at E10. `out_valid` is high from E10.
- Minimum block period is 12 cycles: one IDLE accept cycle, 9 ROUND, 1 FINAL, and at least one DONE cycle.
- `rk_addr` sequence over one block: 10, 9, 8, …, 1, 0, one value per cycle, with no gaps.
- Consumer back-pressure: `out_ready` held low keeps DONE indefinitely, with `out_block` unchanged.
- Reset asserted mid-block returns to reset values immediately (asynchronous). No partial output is produced.

## Configuration
- `AES_DEC_CTRL_ABORT_EN` defined: adds the `abort` input, sampled at the clock edge.
  - `abort`=1 in ROUND, FINAL or DONE: next state IDLE, `st` <= 0, `rc` <= 0, `out_valid` drops at that edge.
  - `abort` in IDLE has no effect. `abort` takes priority over the `out_valid & out_ready` handshake.
- Not defined: no `abort` port. A block always runs to completion.

## Test plan
- FIPS-197 C.1: key 000102…0f expanded into the key store; `in_block`=69c4e0d86a7b0430d8cdb78070b4c55a. Require `out_block`=00112233445566778899aabbccddeeff with `out_valid` high exactly 10 edges after accept.
- Key-fetch order: check `rk_addr`=10,9,…,0 on consecutive cycles, `dp_last`=1 only on the cycle where `rk_addr`=0, and `busy` high for exactly 10 cycles.
- Back-pressure: hold `out_ready`=0 for 20 cycles. `out_valid` stays 1, `out_block` stays stable, `in_ready` stays 0. Raising `out_ready` returns the controller to IDLE on the next edge.
- Back-to-back: two blocks with `in_valid` held high and `out_ready`=1. Both decrypt correctly, accepts are 12 cycles apart, and `in_ready`=0 throughout busy.
- Reset mid-block: deassert `rst_n` at round 5. All outputs take their reset values asynchronously. The next block (C.1 vector) decrypts correctly.
- With `AES_DEC_CTRL_ABORT_EN` defined: pulse `abort` at ROUND `rc`=4. The controller is in IDLE next cycle with `out_valid` never asserted, and a following block decrypts correctly.
